// File: rtl/rr_arbiter8_if.sv
// Requester-bank <-> arbiter bundle: request/enable in, registered grant out.
// The arbiter connects to the slave modport, the requester side to master.
interface rr_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    modport master (
        output en,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  en,
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant, binary index,
// optional hold limit and a guaranteed dead cycle between any two grants.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam bit               HOLD_EN  = (MAX_HOLD != 0);

    state_t           state_q;
    logic [2:0]       ptr_q;
    logic [2:0]       idx_q;
    logic [7:0]       grant_q;
    logic             valid_q;
    logic             preempt_q;
    logic [CNT_W-1:0] cnt_q;

    logic             found_d;
    logic [2:0]       idx_d;
    logic [7:0]       grant_d;
    logic             release_d;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        found_d = 1'b0;
        idx_d   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[ptr_q + 3'(i)]) begin
                found_d = 1'b1;
                idx_d   = ptr_q + 3'(i);
            end
        end
        grant_d = 8'(1) << idx_d;
    end

    assign release_d = !bus.req[idx_q] || (HOLD_EN && (cnt_q == HOLD_LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            grant_q   <= 8'd0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en && found_d) begin
                        grant_q <= grant_d;
                        idx_q   <= idx_d;
                        valid_q <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_d) begin
                        grant_q   <= 8'd0;
                        idx_q     <= 3'd0;
                        valid_q   <= 1'b0;
                        cnt_q     <= '0;
                        ptr_q     <= idx_q + 3'd1;
                        // A drop coinciding with the limit counts as a normal release.
                        preempt_q <= bus.req[idx_q];
                        state_q   <= IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): vector table plus
// hand-written hold-limit rotation and asynchronous-reset sequences.
module tb_rr_arbiter8;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] eg;
        logic [2:0] eidx;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    rr_arbiter8_if bus();

    rr_arbiter8 #(
        .MAX_HOLD(4),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req_v);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] eidx,
                             input logic epre);
        chk({tag, " grant"}, 32'(bus.grant), 32'(eg));
        chk({tag, " idx"}, 32'(bus.grant_idx), 32'(eidx));
        chk({tag, " valid"}, 32'(bus.grant_valid), 32'(eg != 8'd0));
        chk({tag, " preempt"}, 32'(bus.preempt), 32'(epre));
    endtask

    task automatic add(input logic en, input logic [7:0] req, input logic [7:0] eg,
                       input logic [2:0] eidx);
        vec_t v;
        v.en = en; v.req = req; v.eg = eg; v.eidx = eidx;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'd0;
        @(posedge clk); #1;
        check_out("reset", 8'd0, 3'd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] eg;
        total = 0;
        bad   = 0;

        // Single requester: 3 granted cycles, release leaves ptr=1.
        add(1, 8'h01, 8'h01, 0);
        add(1, 8'h01, 8'h01, 0);
        add(1, 8'h01, 8'h01, 0);
        add(1, 8'h00, 8'h00, 0);
        add(1, 8'h00, 8'h00, 0);
        // en low blocks arbitration, en high grants, en low while busy keeps grant.
        for (int i = 0; i < 5; i++) add(0, 8'h10, 8'h00, 0);
        add(1, 8'h10, 8'h10, 4);
        add(0, 8'h10, 8'h10, 4);
        add(0, 8'h10, 8'h10, 4);
        add(0, 8'h00, 8'h00, 0);
        // ptr=5, req=09 -> idx 0; next arbitration from ptr=1 -> idx 3.
        add(1, 8'h09, 8'h01, 0);
        add(1, 8'h09, 8'h01, 0);
        add(1, 8'h08, 8'h00, 0);
        add(1, 8'h09, 8'h08, 3);
        add(1, 8'h08, 8'h08, 3);
        add(1, 8'h00, 8'h00, 0);
        // ptr=4, owner 2 drops on the 4th granted cycle: normal release, no preempt.
        for (int i = 0; i < 4; i++) add(1, 8'h04, 8'h04, 2);
        add(1, 8'h00, 8'h00, 0);
        add(1, 8'h00, 8'h00, 0);

        do_reset();
        foreach (vecs[i]) begin
            bus.en  = vecs[i].en;
            bus.req = vecs[i].req;
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eidx, 1'b0);
        end

        // All requesting: 4-cycle holds, preempted dead cycle, rotation wraps 7 -> 0.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            eg = 8'h01 << (k % 8);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                check_out($sformatf("rot k%0d c%0d", k, c), eg, 3'(k % 8), 1'b0);
            end
            @(posedge clk); #1;
            check_out($sformatf("rot dead k%0d", k), 8'h00, 3'd0, 1'b1);
        end

        // Move ptr to 4, grant owner 6, then reset asynchronously mid-grant.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h08;
        @(posedge clk); #1;
        check_out("pre grant3", 8'h08, 3'd3, 1'b0);
        bus.req = 8'h00;
        @(posedge clk); #1;
        bus.req = 8'h40;
        @(posedge clk); #1;
        check_out("grant6", 8'h40, 3'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async reset", 8'h00, 3'd0, 1'b0);
        bus.req = 8'h41;
        @(posedge clk); #1;
        check_out("held in reset", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_out("after reset", 8'h01, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
